// File: rtl/life_pkg.sv
// life_pkg: shared types and constants for the Game-of-Life generation scheduler
package life_pkg;
  localparam int GRID_W = 64;
  localparam logic [GRID_W-1:0] DEFAULT_SEED = 64'h0412_6424_0034_3C28;
  typedef enum logic [1:0] {S_CLEAR, S_RAND, S_WAIT, S_STEP} sched_state_t;
endpackage

// File: rtl/life_tick_div.sv
// life_tick_div: clearable, enableable divider with a one-cycle terminal-count strobe
module life_tick_div #(
  parameter int DIV = 4,
  parameter int W = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [W-1:0] cnt;
  assign tc = en && cnt == W'(DIV - 1);
  // count enabled cycles, wrapping to zero on terminal count
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + 1'b1;
endmodule

// File: rtl/life_gen_scheduler.sv
// life_gen_scheduler: paces Game-of-Life generations and owns the grid register
module life_gen_scheduler import life_pkg::*; #(
  parameter int TICK_DIV = 12_500_000,
  parameter int DIV_W = 24,
  parameter int GEN_W = 16,
  parameter logic [GRID_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rst,
  input  logic              strt,
  input  logic              rnd,
  input  logic [GRID_W-1:0] lfsr_q,
  output logic              lfsr_load,
  output logic              lfsr_en,
  output logic              step_req,
  input  logic [GRID_W-1:0] next_grid,
  input  logic              next_valid,
  output logic [GRID_W-1:0] grid,
  output logic [GEN_W-1:0]  gen_count,
  output logic              stable,
  output logic              extinct
);
  sched_state_t state, nxt;
  logic run, tc, commit, idle;
  assign run = strt && !rst && !rnd;
  assign idle = state == S_CLEAR || state == S_RAND;
  assign commit = state == S_STEP && run && next_valid;
  assign lfsr_load = state == S_CLEAR;
  assign lfsr_en = state == S_RAND;
  assign step_req = state == S_STEP;
  life_tick_div #(.DIV(TICK_DIV), .W(DIV_W)) u_tick (
    .clk(clk),
    .reset(reset),
    .clr(state != S_WAIT),
    .en(state == S_WAIT && run),
    .tc(tc)
  );
  // mode priority rst > rnd > strt; with no mode asserted the state holds
  always_comb
    nxt = rst ? S_CLEAR :
          rnd ? S_RAND :
          idle ? (strt ? S_WAIT : state) :
          state == S_WAIT ? (tc ? S_STEP : S_WAIT) :
          (commit ? S_WAIT : S_STEP);
  // grid, generation count and status flags follow the state actions
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_CLEAR;
      grid <= SEED;
      gen_count <= '0;
      stable <= 1'b0;
      extinct <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_CLEAR) grid <= SEED;
      else if (state == S_RAND && rnd && !rst) grid <= lfsr_q;
      else if (commit) grid <= next_grid;
      if (idle) begin
        gen_count <= '0;
        stable <= 1'b0;
        extinct <= 1'b0;
      end else if (commit) begin
        gen_count <= &gen_count ? gen_count : gen_count + 1'b1;
        stable <= next_grid == grid;
        extinct <= next_grid == '0;
      end
    end
endmodule

// File: tb/tb_life_gen_scheduler.sv
// tb_life_gen_scheduler: randomized and directed checks against a behavioural model
module tb_life_gen_scheduler;
  localparam int TD = 4;
  localparam logic [63:0] SEED = 64'h0412_6424_0034_3C28;
  localparam int P_CLR = 0, P_RAND = 1, P_WAIT = 2, P_STEP = 3;
  logic clk = 0, reset = 1, rst = 1, strt = 0, rnd = 0, next_valid = 0;
  logic [63:0] lfsr_q = '0, next_grid = '0;
  logic lfsr_load, lfsr_en, step_req, stable, extinct;
  logic [63:0] grid;
  logic [15:0] gen_count;
  logic s_load, s_en, s_req, s_stable, s_extinct;
  logic [63:0] s_grid;
  logic [1:0] s_gen;
  life_gen_scheduler #(.TICK_DIV(TD), .DIV_W(4), .GEN_W(16)) dut (
    .clk(clk), .reset(reset), .rst(rst), .strt(strt), .rnd(rnd), .lfsr_q(lfsr_q),
    .lfsr_load(lfsr_load), .lfsr_en(lfsr_en), .step_req(step_req), .next_grid(next_grid),
    .next_valid(next_valid), .grid(grid), .gen_count(gen_count), .stable(stable), .extinct(extinct)
  );
  life_gen_scheduler #(.TICK_DIV(TD), .DIV_W(4), .GEN_W(2)) dut_small (
    .clk(clk), .reset(reset), .rst(rst), .strt(strt), .rnd(rnd), .lfsr_q(lfsr_q),
    .lfsr_load(s_load), .lfsr_en(s_en), .step_req(s_req), .next_grid(next_grid),
    .next_valid(next_valid), .grid(s_grid), .gen_count(s_gen), .stable(s_stable), .extinct(s_extinct)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  int ph, wait_left, m_gen, step_cyc, resp, slow;
  logic [63:0] m_grid;
  bit m_st, m_ex;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    ph = P_CLR; m_grid = SEED; m_gen = 0; m_st = 0; m_ex = 0; wait_left = TD; step_cyc = 0;
  endtask
  task automatic model_edge();
    int nph;
    nph = ph;
    if (ph == P_CLR || ph == P_RAND) begin
      if (ph == P_CLR) m_grid = SEED;
      else if (rnd && !rst) m_grid = lfsr_q;
      m_gen = 0; m_st = 0; m_ex = 0;
      nph = rst ? P_CLR : rnd ? P_RAND : strt ? P_WAIT : ph;
    end else if (rst) nph = P_CLR;
    else if (rnd) nph = P_RAND;
    else if (strt && ph == P_WAIT) begin
      wait_left--;
      if (wait_left == 0) nph = P_STEP;
    end else if (strt && next_valid) begin
      m_st = next_grid == m_grid;
      m_ex = next_grid == 0;
      m_grid = next_grid;
      m_gen++;
      nph = P_WAIT;
    end
    step_cyc = (nph == P_STEP && ph == P_STEP) ? step_cyc + 1 : 0;
    if (nph == P_WAIT && ph != P_WAIT) wait_left = TD;
    ph = nph;
  endtask
  task automatic check_all();
    check("step_req", step_req, ph == P_STEP);
    check("lfsr_load", lfsr_load, ph == P_CLR);
    check("lfsr_en", lfsr_en, ph == P_RAND);
    check("grid", grid, m_grid);
    check("gen_count", gen_count, m_gen);
    check("gen_sat", s_gen, m_gen > 3 ? 3 : m_gen);
    check("stable", stable, m_st);
    check("extinct", extinct, m_ex);
  endtask
  task automatic cycle();
    next_grid = resp == 0 ? m_grid + 1 : resp == 1 ? m_grid : resp == 2 ? 64'h0 : {$urandom, $urandom};
    if (slow != 0) next_valid = ph == P_STEP && step_cyc >= 6;
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    #1;
    check_all();
  endtask
  initial begin
    resp = 0; slow = 0;
    model_reset();
    repeat (2) cycle();
    reset = 0;
    repeat (2) cycle();
    rst = 0; rnd = 1;
    for (int k = 1; k <= 5; k++) begin
      lfsr_q = 64'(k);
      cycle();
    end
    rnd = 0;
    repeat (3) cycle();
    check("rand_hold", grid, 64'd5);
    strt = 1; next_valid = 1;
    repeat (1 + 3 * (TD + 1)) cycle();
    check("three_steps", gen_count, 16'd3);
    slow = 1;
    for (int i = 0; i < 40 && m_gen < 4; i++) cycle();
    check("slow_commit", gen_count, 16'd4);
    slow = 0; next_valid = 0;
    for (int i = 0; i < 20 && ph != P_STEP; i++) cycle();
    check("reach_step", step_req, 1'b1);
    rnd = 1; next_valid = 1; next_grid = 64'hdead;
    cycle();
    check("abort_en", lfsr_en, 1'b1);
    cycle();
    check("abort_gen", gen_count, 16'd0);
    rnd = 0; resp = 1;
    repeat (TD + 2) cycle();
    check("stable_set", stable, 1'b1);
    resp = 2;
    repeat (TD + 1) cycle();
    check("extinct_set", extinct, 1'b1);
    check("stable_clr", stable, 1'b0);
    repeat (TD + 1) cycle();
    check("both_set", {stable, extinct}, 2'b11);
    resp = 0;
    repeat (5 * (TD + 1)) cycle();
    check("saturate", s_gen, 2'd3);
    next_valid = 0;
    for (int i = 0; i < 20 && ph != P_STEP; i++) cycle();
    #3 reset = 1;
    #1 model_reset();
    check_all();
    rst = 1;
    #1 reset = 0;
    repeat (2) cycle();
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      rst = r < 3;
      rnd = r >= 3 && r < 10;
      strt = r >= 10 && r < 92;
      next_valid = $urandom_range(0, 1);
      resp = $urandom_range(0, 3);
      lfsr_q = {$urandom, $urandom};
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
